acc_unload: RTL

- Drains the 256-coefficient accumulator RAM once it reports end_op, in ascending address order.
- Drives the accumulator's read/ad_out port pair and captures r_out.
- Packs WIDTH/16 coefficients per word and streams the words out over a valid/ready interface.
- Pulses load to return the accumulator to IDLE, then signals done. Sits between the accumulator and the output bus/encoder.

---
 rtl/acc_unload_pkg.sv | 21 ++
 rtl/acc_unload_fifo.sv | 55 +++++
 rtl/acc_unload.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/acc_unload_pkg.sv
// Shared constants and FSM encoding for the accumulator unload path.
package acc_unload_pkg;

  localparam int COEF_W = 16;
  localparam int N_COEF = 256;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ACC = 3'd1,
    ST_READ     = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_LOAD     = 3'd4,
    ST_FIN      = 3'd5
  } state_t;

  function automatic int coefs_per_word(input int width);
    return width / COEF_W;
  endfunction

endpackage

// File: rtl/acc_unload_fifo.sv
// Small synchronous word FIFO; pop-before-push lets a full FIFO accept a push in the same cycle it is popped.
// Zero-latency empty flag (registered count); data readable from head while non-empty.
module acc_unload_fifo #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int AW         = $clog2(FIFO_DEPTH),
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/acc_unload.sv
// Drains the 256-entry accumulator RAM in address order, packing WIDTH/16 coefficients per output word.
// First word CPW+1 cycles after first read; reads stall when no FIFO slot can be reserved, so nothing is dropped.
module acc_unload
  import acc_unload_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              end_op_acc,
  output logic              read_acc,
  output logic [ADDR_W-1:0] ad_out_acc,
  input  logic [COEF_W-1:0] r_out_acc,
  output logic              load_acc,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam int CPW = coefs_per_word(WIDTH);
  localparam int SW  = (CPW > 1) ? $clog2(CPW) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);
  localparam logic [CW:0]       DEPTH_L   = (CW+1)'(FIFO_DEPTH);

  state_t            state_q;
  logic              read_q;
  logic              load_q;
  logic              done_q;
  logic              busy_q;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     resv_q, resv_d;
  logic              issue_q;
  logic [SW-1:0]     slot_q;
  logic [WIDTH-1:0]  pack_q, pack_d;

  logic [SW-1:0]     slot;
  logic              first;
  logic              issue;
  logic              reserve;
  logic              cap_last;
  logic              fifo_push;
  logic              fifo_pop;
  logic [WIDTH-1:0]  pack_word;
  logic [WIDTH-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     occ;
  logic [CW:0]       used;
  logic              slot_ok;
  logic              flush_done;

  assign slot  = (CPW == 1) ? '0 : addr_q[SW-1:0];
  assign first = (slot == '0);

  // A word's pop this cycle already frees its slot, so back-to-back words keep full rate.
  assign used    = {1'b0, resv_q} + {1'b0, occ} - {{CW{1'b0}}, fifo_pop};
  assign slot_ok = (used < DEPTH_L);

  assign issue   = (state_q == ST_READ) && (!first || slot_ok);
  assign reserve = issue && first;

  assign cap_last  = issue_q && (slot_q == SW'(CPW - 1));
  assign fifo_push = cap_last && (!fifo_full || fifo_pop);
  assign fifo_pop  = dout_valid && dout_ready;

  assign flush_done = !issue_q && fifo_empty && (resv_q == '0);

  always_comb begin
    pack_word = pack_q;
    for (int s = 0; s < CPW; s++) begin
      if (slot_q == SW'(s)) pack_word[s*COEF_W +: COEF_W] = r_out_acc;
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == ST_IDLE && start) begin
      addr_d = '0;
    end else if (issue && addr_q != LAST_ADDR) begin
      addr_d = addr_q + 1'b1;
    end
    resv_d = resv_q + CW'(reserve) - CW'(fifo_push);
    pack_d = issue_q ? pack_word : pack_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      resv_q  <= '0;
      issue_q <= 1'b0;
      slot_q  <= '0;
      pack_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      resv_q  <= resv_d;
      issue_q <= issue;
      slot_q  <= slot;
      pack_q  <= pack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WAIT_ACC;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT_ACC: begin
          if (end_op_acc) begin
            state_q <= ST_READ;
            read_q  <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue && addr_q == LAST_ADDR) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state_q <= ST_LOAD;
            read_q  <= 1'b0;
            load_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_FIN;
          load_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
          load_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  acc_unload_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (pack_word),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dout),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (occ)
  );

  assign read_acc   = read_q;
  assign ad_out_acc = addr_q;
  assign load_acc   = load_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign dout_valid = !fifo_empty;
  assign dout       = dout_valid ? fifo_dout : '0;

endmodule
